// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : iterative_alu
// Purpose  : Registered ALU with start/busy/done handshake. Single-cycle
//            logic/arith/compare/shift ops plus iterative shift-add multiply
//            and restoring unsigned divide/remainder.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    ITER   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  // Operands latched at acceptance; later input changes have no effect.
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    count;
  // acc: product accumulator (MUL) or partial remainder (DIVU/REMU).
  // work: multiplier shifting right (MUL) or dividend/quotient shifting left.
  // mcand: multiplicand shifting left (MUL only).
  logic [WIDTH-1:0] acc, work, mcand;

  logic             start_is_iter;
  logic [SHW-1:0]   shamt;
  logic signed [WIDTH-1:0] a_signed;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] iter_res;

  assign start_is_iter = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) ||
                         (ALUControl == OP_REMU);
  assign shamt    = b_q[SHW-1:0];
  assign a_signed = a_q;

  // Single-cycle result from the latched operands; unknown codes give 0.
  always_comb begin
    single_res = '0;
    case (op_q)
      OP_AND:  single_res = a_q & b_q;
      OP_OR:   single_res = a_q | b_q;
      OP_ADD:  single_res = a_q + b_q;
      OP_SUB:  single_res = a_q - b_q;
      OP_XOR:  single_res = a_q ^ b_q;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_SLL:  single_res = a_q << shamt;
      OP_SRL:  single_res = a_q >> shamt;
      OP_SRA:  single_res = a_signed >>> shamt;
      default: single_res = '0;
    endcase
  end

  // One iteration step of multiply (shift-add) and divide (restoring).
  always_comb begin
    mul_acc_next = work[0] ? (acc + mcand) : acc;
    div_shift    = {acc, work[WIDTH-1]};
    div_diff     = div_shift - {1'b0, b_q};
    div_ge       = (div_shift >= {1'b0, b_q});
    div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_next = {work[WIDTH-2:0], div_ge};
    case (op_q)
      OP_MUL:  iter_res = mul_acc_next;
      OP_DIVU: iter_res = div_quo_next;
      default: iter_res = div_rem_next;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = start_is_iter ? ITER : SINGLE;
      end
      SINGLE: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      ITER: begin
        busy = 1'b1;
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration registers and the registered result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      count     <= '0;
      acc       <= '0;
      work      <= '0;
      mcand     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= srcA;
            b_q   <= srcB;
            op_q  <= ALUControl;
            count <= CW'(WIDTH);
            acc   <= '0;
            mcand <= srcA;
            work  <= (ALUControl == OP_MUL) ? srcB : srcA;
          end
        end
        SINGLE: begin
          ALUResult <= single_res;
          Zero      <= (single_res == '0);
        end
        ITER: begin
          count <= count - CW'(1);
          if (op_q == OP_MUL) begin
            acc   <= mul_acc_next;
            mcand <= mcand << 1;
            work  <= work >> 1;
          end else begin
            acc   <= div_rem_next;
            work  <= div_quo_next;
          end
          if (count == CW'(1)) begin
            ALUResult <= iter_res;
            Zero      <= (iter_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_alu
// Purpose  : Directed self-checking bench for iterative_alu (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_alu;

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010,
                         SUB = 4'b0011, XOR_ = 4'b0100, SLT = 4'b0101,
                         SLTU = 4'b0110, SLL = 4'b0111, SRL = 4'b1000,
                         SRA = 4'b1001, MUL = 4'b1010, DIVU = 4'b1100,
                         REMU = 4'b1101, BAD = 4'b1011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] srcA = '0, srcB = '0;
  logic [3:0]  ALUControl = '0;
  logic [31:0] ALUResult;
  logic        Zero, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  iterative_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .srcA(srcA), .srcB(srcB),
    .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done. latency counts cycles
  // from the accepting edge to the first cycle with done high; -1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int latency,
                        output int busy_cycles);
    int cyc;
    @(negedge clk);
    start = 1'b1; ALUControl = op; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; srcA = ~a; srcB = ~b; ALUControl = ADD;
    cyc = 1;
    busy_cycles = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cyc++;
    end
    latency = done ? cyc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b, want 0/1/0/0",
               ALUResult, Zero, busy, done);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int lat, bc;
    logic [3:0]  ops [11] = '{SUB, ADD, SRA, SRL, SLT, SLTU, AND_, OR_, XOR_, SLL, BAD};
    logic [31:0] as  [11] = '{32'd5, 32'd3, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00,
                              32'h00000003, 32'h12345678};
    logic [31:0] bs  [11] = '{32'd5, 32'd4, 32'd4, 32'd4, 32'd1, 32'd1, 32'h0FF00FF0,
                              32'h0FF00FF0, 32'h0FF00FF0, 32'h00000024, 32'h1};
    logic [31:0] exp [11] = '{32'd0, 32'd7, 32'hF8000000, 32'h08000000, 32'd1, 32'd0,
                              32'h00F000F0, 32'hFFF0FFF0, 32'hF0F0F0F0, 32'h00000030,
                              32'd0};
    for (int i = 0; i < 11; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bc);
      tests_run++;
      if (lat !== 2 || ALUResult !== exp[i] || Zero !== (exp[i] == 32'h0)) begin
        tests_failed++;
        $display("FAIL single_op%0d(op=%b): lat=%0d result=%h zero=%b, want lat=2 result=%h zero=%b",
                 i, ops[i], lat, ALUResult, Zero, exp[i], (exp[i] == 32'h0));
      end
    end
    // Result holds through IDLE while inputs wiggle.
    repeat (3) @(negedge clk);
    tests_run++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_idle: result=%h zero=%b busy=%b, want 0/1/0", ALUResult, Zero, busy);
    end
  endtask

  task automatic test_iter();
    int lat, bc;
    logic [3:0]  ops [6] = '{MUL, MUL, DIVU, REMU, DIVU, REMU};
    logic [31:0] as  [6] = '{32'd7, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] bs  [6] = '{32'd6, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'd42, 32'd1, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bc);
      tests_run++;
      if (lat !== 33 || bc !== 32 || ALUResult !== exp[i] || Zero !== 1'b0) begin
        tests_failed++;
        $display("FAIL iter_op%0d(op=%b): lat=%0d busy=%0d result=%h zero=%b, want lat=33 busy=32 result=%h zero=0",
                 i, ops[i], lat, bc, ALUResult, Zero, exp[i]);
      end
    end
    run_op(MUL, 32'h12345678, 32'd0, lat, bc);
    tests_run++;
    if (lat !== 33 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_zero: lat=%0d result=%h zero=%b, want 33/0/1", lat, ALUResult, Zero);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    int lat, bc;
    @(negedge clk);
    start = 1'b1; ALUControl = MUL; srcA = 32'd9; srcB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        start = 1'b1; ALUControl = ADD; srcA = 32'd1; srcB = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests_run++;
    if (!done || cyc !== 33 || ALUResult !== 32'd81) begin
      tests_failed++;
      $display("FAIL start_while_busy: lat=%0d done=%b result=%h, want 33/1/%h",
               cyc, done, ALUResult, 32'd81);
    end
    // Now sitting in DONE: a start here must be dropped.
    start = 1'b1; ALUControl = ADD; srcA = 32'd2; srcB = 32'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'd81) begin
      tests_failed++;
      $display("FAIL start_in_done: busy=%b done=%b result=%h, want 0/0/%h",
               busy, done, ALUResult, 32'd81);
    end
    // Back to back: accepted on the following cycle.
    run_op(SUB, 32'd10, 32'd3, lat, bc);
    tests_run++;
    if (lat !== 2 || ALUResult !== 32'd7) begin
      tests_failed++;
      $display("FAIL back_to_back: lat=%0d result=%h, want 2/%h", lat, ALUResult, 32'd7);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    int lat, bc;
    run_op(ADD, 32'd20, 32'd22, lat, bc);  // leave a non-zero result behind
    @(negedge clk);
    start = 1'b1; ALUControl = DIVU; srcA = 32'd1000; srcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);             // now at cycle 10 of the divide
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h zero=%b, want 0/0/0/1",
               busy, done, ALUResult, Zero);
    end
    reset = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++;
      $display("FAIL no_done_after_reset: active cycles=%0d, want 0", seen_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iter();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, registered successor to the processor's combinational ALU, for the multiciclo datapath.
- Adds XOR, compares, shifts, and iterative multiply, unsigned divide and unsigned remainder.
- Uses a start/busy/done handshake so the control FSM can stall on long operations.
- Operands are latched at start. The result stays stable until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), derived shift-amount width. It is a localparam, not overridable.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on rising clk; 0 = reset.
- start  in  1  request operation; accepted only in IDLE.
- srcA  in  WIDTH  first operand.
- srcB  in  WIDTH  second operand (shift amount = srcB[SHW-1:0]).
- ALUControl  in  4  operation select.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  registered; 1 when ALUResult == 0.
- busy  out  1  1 while an accepted operation is in progress.
- done  out  1  one-cycle pulse; ALUResult valid from this cycle on.

Behaviour:
- Reset (reset==0 at clk edge), from any state including mid-operation:
  - state=IDLE, ALUResult=0, Zero=1, busy=0, done=0.
  - Internal counters and accumulators are cleared.
- ALUControl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR.
  - 0101 SLT (signed, result 1/0), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL (low WIDTH bits of product), 1100 DIVU, 1101 REMU.
  - All other codes give result 0.
- Arithmetic is modulo 2^WIDTH; no overflow/carry outputs.
- States: IDLE, SINGLE, ITER, DONE.
- IDLE:
  - busy=0.
  - On start=1, latch srcA, srcB and ALUControl.
  - Single-cycle or illegal op -> SINGLE. MUL/DIVU/REMU -> ITER with counter=WIDTH.
- SINGLE (1 cycle, busy=1): compute from the latched operands, register ALUResult/Zero, -> DONE.
- ITER (busy=1):
  - MUL: shift-add, one multiplier bit per cycle, LSB first.
  - DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
  - Counter decrements each cycle; at counter==1 the final result is registered, -> DONE.
  - Occupies exactly WIDTH cycles.
- DONE (1 cycle):
  - done=1, busy=0, -> IDLE.
  - A start in DONE is ignored; it is accepted from the next cycle on.
- Latency, start edge to done high: single/illegal ops 2 cycles; MUL/DIVU/REMU WIDTH+1 cycles.
- start while busy=1 or in DONE: ignored, no effect on the latched operands. srcA/srcB/ALUControl changes after acceptance have no effect.
- Divide by zero: DIVU result = all ones; REMU result = srcA. Same WIDTH-cycle latency, no exception.
- ALUResult/Zero change only in the cycle the result is registered. They hold their value through IDLE until the next operation completes.
- No $display or other simulation-only side effects in RTL.

Test Plan:
- Reset release, then SUB srcA=5 srcB=5 -> done high 2 cycles after start; ALUResult=0, Zero=1. Then ADD 3+4 -> ALUResult=7, Zero=0.
- SRA srcA=0x80000000 srcB=4 -> ALUResult=0xF8000000. Same operands with SRL -> 0x08000000. SLT srcA=0xFFFFFFFF srcB=1 -> 1; SLTU with the same operands -> 0.
- MUL 7*6 -> busy high 32 cycles, done exactly 33 cycles after start, ALUResult=42. MUL 0xFFFFFFFF*0xFFFFFFFF -> ALUResult=1.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. All complete in 33 cycles.
- start MUL 9*9, then pulse start with ADD 1+1 at cycle 5 -> ignored; result 81 at cycle 33.
- Drive reset=0 at cycle 10 of a DIVU -> next edge: busy=0, done=0, ALUResult=0, Zero=1. No done pulse follows.
